button_debouncer: RTL
=====================

Name: button_debouncer

Overview:
- Front-end conditioning stage for a raw push-button input. Feeds the mode-select state machine directly.
- Synchronises the asynchronous pad signal and rejects contact bounce with a stability counter.
- Emits exactly one single-cycle press pulse per debounced press, which the mode FSM consumes as its advance strobe. Also exposes the debounced level and a release pulse.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops (minimum 2).
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised cycles required to accept a change (10 ms at 100 MHz; minimum 2).
- REPEAT_DELAY, 50000000, hold cycles before the first auto-repeat pulse (used only with the optional feature).
- REPEAT_PERIOD, 20000000, cycles between subsequent auto-repeat pulses (used only with the optional feature).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- btn_in  input  1  raw, asynchronous, bouncing button level (1 = pressed)
- btn_pulse  output  1  one-cycle strobe on accepted press; drives the mode FSM button input
- btn_level  output  1  debounced button level
- btn_release_pulse  output  1  one-cycle strobe on accepted release

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and reset.
- Reset values: all synchroniser flops 0, state IDLE, counter 0, btn_pulse 0, btn_level 0, btn_release_pulse 0. Reset asserted mid-count aborts the count immediately. No pulse is generated on reset release.
- Synchroniser: btn_in passes through SYNC_STAGES flops; the last flop output is btn_s. All logic below uses only btn_s.
- Counter: width $clog2(DEBOUNCE_CYCLES+1), unsigned. It never wraps; it is always cleared on a state change.
- Registered one-hot FSM with states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT:
  - IDLE: if btn_s=1, go to PRESS_WAIT and clear the counter; otherwise stay.
  - PRESS_WAIT:
    - If btn_s=0 (bounce), return to IDLE with no output.
    - Otherwise, if counter == DEBOUNCE_CYCLES-1, go to PRESSED and set btn_pulse=1 for exactly one cycle.
    - Otherwise increment the counter.
  - PRESSED: if btn_s=0, go to RELEASE_WAIT and clear the counter; otherwise stay.
  - RELEASE_WAIT:
    - If btn_s=1, return to PRESSED with no pulse.
    - Otherwise, if counter == DEBOUNCE_CYCLES-1, go to IDLE and set btn_release_pulse=1 for exactly one cycle.
    - Otherwise increment the counter.
- btn_level: 1 in PRESSED and RELEASE_WAIT, 0 in IDLE and PRESS_WAIT. It is decoded from the registered state.
- Latency: with btn_in stable high, btn_pulse is high in the cycle after the (SYNC_STAGES+DEBOUNCE_CYCLES+1)-th rising edge that samples btn_in=1. Release latency is symmetric.
- All outputs are registered, so there are no glitches for the downstream FSM. Pulses are never wider than one cycle and never back-to-back from a single press.
- A glitch shorter than DEBOUNCE_CYCLES in either direction produces no output and no btn_level change.

Optional Feature:
- Macro: BUTTON_DEBOUNCER_AUTO_REPEAT_EN.
- Defined: while in PRESSED, a second counter runs. At REPEAT_DELAY cycles after entry, one extra btn_pulse fires. Another fires every REPEAT_PERIOD cycles after that until the state leaves PRESSED. Leaving PRESSED (including a bounce into RELEASE_WAIT) clears the repeat counter. Returning from RELEASE_WAIT restarts the REPEAT_DELAY wait.
- Undefined: the repeat counter and its logic are absent, and exactly one btn_pulse is produced per press. The REPEAT_* parameters are ignored.

Decomposition:
- Package button_pkg holds:
  - the one-hot state enum, logic [3:0], values IDLE=0001, PRESS_WAIT=0010, PRESSED=0100, RELEASE_WAIT=1000;
  - a function giving counter width from a cycle count.
- Sub-module sync_ff, parameterised by SYNC_STAGES, contains the asynchronous-reset synchroniser chain. It is reusable for other pad inputs.

Test Plan (all runs use DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean press: btn_in 0→1 held 20 cycles → btn_pulse high for 1 cycle after the 7th sampling edge; btn_level rises in that same cycle; btn_release_pulse stays 0.
- Bounce: btn_in toggles 1,0,1,0 each cycle, then held 1 → exactly one btn_pulse, 7 edges after the final rising transition; no pulse during toggling.
- Release with bounce: from PRESSED, btn_in 1→0 for 2 cycles, back to 1, then 0 held → btn_level stays 1 through the glitch; one btn_release_pulse 7 edges after the final fall; btn_level then 0.
- Reset mid-count: btn_in high, reset asserted asynchronously at counter=2 → all outputs 0 immediately; after release with btn_in still high, one btn_pulse 7 edges later.
- Downstream chain: three clean presses into the mode FSM → mode_sel steps 00→01→10→00.
- Auto-repeat (macro defined, REPEAT_DELAY=10, REPEAT_PERIOD=5): hold 30 cycles after the initial pulse → extra pulses at +10, +15, +20, +25, +30; none after release begins.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioning front end.
package button_pkg;

  typedef enum logic [3:0] {
    IDLE         = 4'b0001,
    PRESS_WAIT   = 4'b0010,
    PRESSED      = 4'b0100,
    RELEASE_WAIT = 4'b1000
  } state_e;

  // Bits needed for an unsigned counter that must be able to hold the value 'cycles'.
  function automatic int cnt_width(input int unsigned cycles);
    if (cycles < 1)
      return 1;
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous pad input, cleared by an async reset.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      chain <= '0;
    else
      chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Button synchroniser + debouncer producing a registered level and one-cycle press/release strobes.
// Optional auto-repeat of the press strobe while held: define BUTTON_DEBOUNCER_AUTO_REPEAT_EN.
module button_debouncer
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 20000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_pulse,
  output logic btn_level,
  output logic btn_release_pulse
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_debouncer: parameter out of legal range");
  end

  logic             btn_s;
  logic [3:0]       state;
  logic [3:0]       state_next;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             press_evt;
  logic             release_evt;
  logic             repeat_evt;
  logic             level_next;

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_comb begin
    state_next  = state;
    count_next  = count;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_next = PRESS_WAIT;
          count_next = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_next = IDLE;
          count_next = '0;
        end else if (count == CNT_LAST) begin
          state_next = PRESSED;
          count_next = '0;
          press_evt  = 1'b1;
        end else begin
          count_next = count + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_s) begin
          state_next = RELEASE_WAIT;
          count_next = '0;
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_next = PRESSED;
          count_next = '0;
        end else if (count == CNT_LAST) begin
          state_next  = IDLE;
          count_next  = '0;
          release_evt = 1'b1;
        end else begin
          count_next = count + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = '0;
      end
    endcase
  end

  // The level gets its own flop so the OR of two one-hot bits never reaches the consumer.
  assign level_next = (state_next == PRESSED) || (state_next == RELEASE_WAIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      count             <= '0;
      btn_pulse         <= 1'b0;
      btn_level         <= 1'b0;
      btn_release_pulse <= 1'b0;
    end else begin
      state             <= state_next;
      count             <= count_next;
      btn_pulse         <= press_evt | repeat_evt;
      btn_level         <= level_next;
      btn_release_pulse <= release_evt;
    end
  end

`ifdef BUTTON_DEBOUNCER_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = cnt_width(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_count;
  logic             rpt_phase;
  logic             holding;

  // rpt_phase selects the initial delay (0) or the steady repeat period (1).
  assign holding    = (state == PRESSED) && btn_s;
  assign repeat_evt = holding && (rpt_count == (rpt_phase ? PERIOD_LAST : DELAY_LAST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_count <= '0;
      rpt_phase <= 1'b0;
    end else if (!holding) begin
      rpt_count <= '0;
      rpt_phase <= 1'b0;
    end else if (repeat_evt) begin
      rpt_count <= '0;
      rpt_phase <= 1'b1;
    end else begin
      rpt_count <= rpt_count + 1'b1;
    end
  end
`else
  assign repeat_evt = 1'b0;
`endif

endmodule
